tb_cmd_dispatcher: RTL and testbench
====================================

Name: tb_cmd_dispatcher

Overview:
Testbench command sequencer that sits directly upstream of the wait_event stage and its sibling stimulus modules. It accepts one tokenised scenario command at a time (string args array with a valid/ready handshake) and classifies it by keyword. It then drives the matching target's select and args_valid strobe, holds the args stable, and waits for that target's done pulse before accepting the next command. It also executes plain time delays itself, and supervises each command with a watchdog and an error counter.

Parameters:
ARGS_NB, 5, number of string tokens per command (token 0 = keyword)
CLK_PERIOD, 1000, clk period in ps, used for delay conversion
WATCHDOG_CYCLES, 100000, max cycles a target may stay busy before forced abort
CNT_WIDTH, 16, width of command and error counters

Ports:
clk  input  1  testbench clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
i_cmd_valid  input  1  command tokens on i_args are valid
o_cmd_ready  output  1  dispatcher can accept a command
i_args  input  string[ARGS_NB]  tokenised command
o_args  output  string[ARGS_NB]  latched command, forwarded to all targets
o_args_valid  output  1  one-cycle strobe to the selected target
o_sel_wait  output  1  wait_event selected (WTR/WTF)
o_sel_set  output  1  set-injector selected (SET)
o_sel_chk  output  1  checker selected (CHK)
i_wait_done  input  1  done pulse from wait_event
i_set_done  input  1  done pulse from set-injector
i_chk_done  input  1  done pulse from checker
o_error  output  1  one-cycle pulse on any dispatch error
o_err_cnt  output  CNT_WIDTH  saturating error count
o_cmd_cnt  output  CNT_WIDTH  wrapping count of completed commands
o_finished  output  1  END command executed, sticky

Behaviour:
- Reset (rst=1 at an edge): state IDLE; o_cmd_ready=0 for that cycle, then 1. All o_sel_*, o_args_valid, o_error and o_finished are 0. o_err_cnt and o_cmd_cnt are 0. o_args are set to "" and all timers are cleared. Reset mid-command aborts it silently, with no o_error.
- States: IDLE, DECODE, BUSY, DELAY, FINISHED.
- IDLE: o_cmd_ready=1. At an edge with i_cmd_valid=1, latch i_args into o_args, drop ready and go to DECODE.
- DECODE (1 cycle), keyword o_args[0]:
  - "WTR"/"WTF": next edge o_sel_wait=1, o_args_valid=1, go to BUSY.
  - "SET": as above with o_sel_set.
  - "CHK": as above with o_sel_chk.
  - "WAIT": convert o_args[1].atoi() by unit o_args[2] (ps/ns/us/ms → ×1/×1e3/×1e6/×1e9, then /CLK_PERIOD, integer truncation) and go to DELAY. A result of 0 cycles completes at the next edge.
  - "END": set o_finished and go to FINISHED.
  - Any other keyword, or an illegal WAIT unit: o_error pulse, o_err_cnt+1, back to IDLE, o_cmd_cnt unchanged.
- Issue latency: accept edge N, DECODE at N, select plus args_valid registered at N+1, args_valid cleared at N+2.
- BUSY:
  - The selected o_sel_* stays high and o_args stays frozen the whole time; the target samples o_args[1] continuously.
  - On the edge where the matching done input is 1: clear o_sel_*, o_cmd_cnt+1, go to IDLE (ready=1 from that edge).
  - Done pulses from non-selected targets are ignored.
  - The watchdog counts BUSY cycles. On reaching WATCHDOG_CYCLES: clear sel, o_error pulse, o_err_cnt+1, go to IDLE with o_cmd_cnt unchanged.
  - If done and watchdog expiry coincide, done wins.
- DELAY: down-count from N. At 0: o_cmd_cnt+1, go to IDLE. A DELAY of N cycles returns ready exactly N+1 cycles after DECODE.
- FINISHED: terminal. o_cmd_ready=0 and i_cmd_valid is ignored; only rst leaves this state.
- o_err_cnt saturates at all-ones. o_cmd_cnt wraps modulo 2^CNT_WIDTH.
- At most one o_sel_* is high at any time.

Decomposition:
- Package tb_cmd_pkg holds:
  - state enum and target enum (NONE/WAIT/SET/CHK);
  - keyword string constants;
  - a unit-to-ps function;
  - a keyword-classify function.
- One sub-module, tb_cycle_timer: load value, enable, expired flag. It is instanced twice, for the DELAY counter and for the watchdog.

Test Plan:
- After reset, check ready=1 at the first post-reset cycle. Send "WTR sig0"; i_wait_done pulses 20 cycles later → o_sel_wait high for 21 cycles, o_args_valid exactly 1 cycle at N+1, o_cmd_cnt=1.
- "WAIT 10 ns" with CLK_PERIOD=1000 → ready returns 11 cycles after DECODE; "WAIT 0 ps" → ready returns in 1 cycle.
- "FOO" → o_error one pulse, o_err_cnt=1, no sel asserted. "WAIT 5 xs" → o_err_cnt=2.
- WATCHDOG_CYCLES=50, "CHK x" with no done → abort at cycle 50, o_err_cnt=1. Repeat with i_chk_done arriving on cycle 50 → completes with no error.
- "SET a" with a stray i_wait_done pulse while BUSY → ignored; completes only on i_set_done.
- "END" → o_finished=1 and ready stays 0; rst asserted in mid-BUSY of a previous command → all outputs return to reset values, no error.

Source files
------------

// File: rtl/tb_cmd_pkg.sv
// Shared types and helpers for the scenario command dispatcher.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tb_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_BUSY,
    ST_DELAY,
    ST_FINISHED
  } state_e;

  // Which downstream stimulus module currently owns the command.
  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_WAIT,
    TGT_SET,
    TGT_CHK
  } tgt_e;

  // Result of classifying token 0 of a command.
  typedef enum logic [2:0] {
    CK_WAIT_EVT,
    CK_SET,
    CK_CHK,
    CK_DELAY,
    CK_END,
    CK_BAD
  } cmd_kind_e;

  localparam string KW_WTR  = "WTR";
  localparam string KW_WTF  = "WTF";
  localparam string KW_SET  = "SET";
  localparam string KW_CHK  = "CHK";
  localparam string KW_WAIT = "WAIT";
  localparam string KW_END  = "END";

  // Picoseconds per unit token; -1 marks an unknown unit.
  function automatic longint unit_to_ps(input string unit);
    if (unit == "ps") return 64'sd1;
    if (unit == "ns") return 64'sd1000;
    if (unit == "us") return 64'sd1000000;
    if (unit == "ms") return 64'sd1000000000;
    return -64'sd1;
  endfunction

  function automatic longint str_to_int(input string s);
    return longint'(s.atoi());
  endfunction

  function automatic cmd_kind_e classify_kw(input string kw);
    if (kw == KW_WTR || kw == KW_WTF) return CK_WAIT_EVT;
    if (kw == KW_SET)  return CK_SET;
    if (kw == KW_CHK)  return CK_CHK;
    if (kw == KW_WAIT) return CK_DELAY;
    if (kw == KW_END)  return CK_END;
    return CK_BAD;
  endfunction

  function automatic tgt_e kind_to_tgt(input cmd_kind_e kind);
    case (kind)
      CK_WAIT_EVT: return TGT_WAIT;
      CK_SET:      return TGT_SET;
      CK_CHK:      return TGT_CHK;
      default:     return TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tb_cmd_dispatcher_if.sv
// Command/target bus between a scenario source, the dispatcher and its targets.
// Latency: n/a (wires only).
// Backpressure: command side is valid/ready; target side is select + done pulse.
//   i_cmd_valid/o_cmd_ready/i_args : command handshake into the dispatcher
//   o_args/o_args_valid/o_sel_*    : latched command and target selects out
//   i_wait_done/i_set_done/i_chk_done : completion pulses from the targets
interface tb_cmd_dispatcher_if #(
  parameter int ARGS_NB = 5
);
  logic  i_cmd_valid;
  logic  o_cmd_ready;
  string i_args [ARGS_NB];
  string o_args [ARGS_NB];
  logic  o_args_valid;
  logic  o_sel_wait;
  logic  o_sel_set;
  logic  o_sel_chk;
  logic  i_wait_done;
  logic  i_set_done;
  logic  i_chk_done;

  // Dispatcher side.
  modport slave (
    input  i_cmd_valid, i_args, i_wait_done, i_set_done, i_chk_done,
    output o_cmd_ready, o_args, o_args_valid, o_sel_wait, o_sel_set, o_sel_chk
  );

  // Scenario source / target side.
  modport master (
    output i_cmd_valid, i_args, i_wait_done, i_set_done, i_chk_done,
    input  o_cmd_ready, o_args, o_args_valid, o_sel_wait, o_sel_set, o_sel_chk
  );
endinterface

// File: rtl/tb_cycle_timer.sv
// Loadable down-counter: expired is high while the count sits at zero.
// Latency: load takes effect at the next edge; one decrement per enabled edge.
// Backpressure: none; the count holds at zero until reloaded.
//   load/load_val : reload the counter
//   en            : decrement while nonzero
//   expired       : count is zero
module tb_cycle_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/tb_cmd_dispatcher.sv
// Scenario command sequencer: classifies one tokenised command, hands it to a target or runs a delay.
// Latency: accept at edge N, select + args_valid from edge N+1, args_valid gone at N+2.
// Backpressure: o_cmd_ready stays low until the current command completes, errors or is aborted.
//   clk, rst        : clock and synchronous active-high reset
//   bus (slave)     : command handshake in, latched args / selects out, target done pulses in
//   o_error         : one-cycle pulse per dispatch error
//   o_err_cnt       : saturating error count
//   o_cmd_cnt       : wrapping completed-command count
//   o_finished      : sticky, END executed
module tb_cmd_dispatcher
  import tb_cmd_pkg::*;
#(
  parameter int ARGS_NB         = 5,
  parameter int CLK_PERIOD      = 1000,
  parameter int WATCHDOG_CYCLES = 100000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tb_cmd_dispatcher_if.slave   bus,
  output logic                 o_error,
  output logic [CNT_WIDTH-1:0] o_err_cnt,
  output logic [CNT_WIDTH-1:0] o_cmd_cnt,
  output logic                 o_finished
);

  localparam int TW = 32;

  state_e    state_q, state_d;
  tgt_e      tgt_q;
  logic      issue_q;

  cmd_kind_e kind;
  longint    unit_ps;
  logic      unit_ok;
  longint    delay_cyc;
  logic      done_sel;
  logic      dly_expired, wd_expired;
  logic      dly_load, wd_load;
  logic      cmd_done, err_evt;

  // Decode the latched command; only meaningful while in DECODE.
  always_comb begin
    kind      = classify_kw(bus.o_args[0]);
    unit_ps   = unit_to_ps(bus.o_args[2]);
    unit_ok   = (unit_ps > 0);
    delay_cyc = 0;
    if (unit_ok) begin
      delay_cyc = (str_to_int(bus.o_args[1]) * unit_ps) / longint'(CLK_PERIOD);
    end
    if (delay_cyc < 0) begin
      delay_cyc = 0;
    end
  end

  // Only the selected target's done pulse counts; the others are stray.
  always_comb begin
    done_sel = 1'b0;
    case (tgt_q)
      TGT_WAIT: done_sel = bus.i_wait_done;
      TGT_SET:  done_sel = bus.i_set_done;
      TGT_CHK:  done_sel = bus.i_chk_done;
      default:  done_sel = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= TGT_NONE;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= (state_q == ST_DECODE) && (state_d == ST_BUSY);
      if (state_q == ST_DECODE) begin
        tgt_q <= kind_to_tgt(kind);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (kind)
          CK_WAIT_EVT, CK_SET, CK_CHK: state_d = ST_BUSY;
          CK_DELAY: state_d = unit_ok ? ST_DELAY : ST_IDLE;
          CK_END:   state_d = ST_FINISHED;
          default:  state_d = ST_IDLE;
        endcase
      end
      ST_BUSY: begin
        // A done on the expiry edge still completes the command.
        if (done_sel || wd_expired) state_d = ST_IDLE;
      end
      ST_DELAY: begin
        if (dly_expired) state_d = ST_IDLE;
      end
      ST_FINISHED: state_d = ST_FINISHED;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    bus.o_cmd_ready  = (state_q == ST_IDLE) && !rst;
    bus.o_sel_wait   = (state_q == ST_BUSY) && (tgt_q == TGT_WAIT);
    bus.o_sel_set    = (state_q == ST_BUSY) && (tgt_q == TGT_SET);
    bus.o_sel_chk    = (state_q == ST_BUSY) && (tgt_q == TGT_CHK);
    bus.o_args_valid = (state_q == ST_BUSY) && issue_q;
    o_finished       = (state_q == ST_FINISHED);
  end

  assign cmd_done = ((state_q == ST_BUSY) && done_sel) ||
                    ((state_q == ST_DELAY) && dly_expired);
  assign err_evt  = ((state_q == ST_DECODE) &&
                     ((kind == CK_BAD) || ((kind == CK_DELAY) && !unit_ok))) ||
                    ((state_q == ST_BUSY) && !done_sel && wd_expired);

  assign dly_load = (state_q == ST_DECODE) && (kind == CK_DELAY) && unit_ok;
  assign wd_load  = (state_q == ST_DECODE) && (state_d == ST_BUSY);

  // Args latch, error pulse and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARGS_NB; i++) begin
        bus.o_args[i] <= "";
      end
      o_error   <= 1'b0;
      o_err_cnt <= '0;
      o_cmd_cnt <= '0;
    end else begin
      if ((state_q == ST_IDLE) && bus.i_cmd_valid) begin
        for (int i = 0; i < ARGS_NB; i++) begin
          bus.o_args[i] <= bus.i_args[i];
        end
      end
      o_error <= err_evt;
      if (err_evt && (o_err_cnt != '1)) begin
        o_err_cnt <= o_err_cnt + CNT_WIDTH'(1);
      end
      if (cmd_done) begin
        o_cmd_cnt <= o_cmd_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Delay of N cycles: loaded with N on the DECODE edge, leaves after N+1 DELAY cycles.
  tb_cycle_timer #(.WIDTH(TW)) u_dly_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (TW'(delay_cyc)),
    .en       (state_q == ST_DELAY),
    .expired  (dly_expired)
  );

  // Loaded with WATCHDOG_CYCLES-1 so it reads expired in the last allowed BUSY cycle.
  tb_cycle_timer #(.WIDTH(TW)) u_wd_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (TW'(WATCHDOG_CYCLES - 1)),
    .en       (state_q == ST_BUSY),
    .expired  (wd_expired)
  );

endmodule

// File: tb/tb_tb_cmd_dispatcher.sv
// Scoreboard bench for the command dispatcher: stimulus pushes expected per-command responses,
// a negedge monitor rebuilds each observed response and compares it.
// Watchdog is shortened to 50 cycles so expiry is reachable.
module tb_tb_cmd_dispatcher;

  localparam int ARGS_NB = 5;
  localparam int CW      = 16;

  logic          clk;
  logic          rst;
  logic          o_error;
  logic [CW-1:0] o_err_cnt;
  logic [CW-1:0] o_cmd_cnt;
  logic          o_finished;

  tb_cmd_dispatcher_if #(.ARGS_NB(ARGS_NB)) bus();

  tb_cmd_dispatcher #(
    .ARGS_NB         (ARGS_NB),
    .CLK_PERIOD      (1000),
    .WATCHDOG_CYCLES (50),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_error    (o_error),
    .o_err_cnt  (o_err_cnt),
    .o_cmd_cnt  (o_cmd_cnt),
    .o_finished (o_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passes;

  typedef struct {
    int low;      // cycles with ready low before the closing cycle
    int sw;
    int ss;
    int sc;
    int av;
    int av_idx;   // cycle index of args_valid, accept cycle is 0
    int err;
    int multi;    // cycles with more than one select high
    int cmd_cnt;
    int err_cnt;
    int fin;
  } resp_t;

  resp_t exp_q [$];
  string tag_q [$];
  string arg_q [$];

  task automatic check_int(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
  endtask

  task automatic expect_resp(input string tag, input int low, input int sw, input int ss,
                             input int sc, input int av, input int err, input int cmd,
                             input int errc, input int fin, input string arg1);
    resp_t r;
    r.low = low; r.sw = sw; r.ss = ss; r.sc = sc; r.av = av;
    r.av_idx = (av > 0) ? 1 : -1;
    r.err = err; r.multi = 0; r.cmd_cnt = cmd; r.err_cnt = errc; r.fin = fin;
    exp_q.push_back(r);
    tag_q.push_back(tag);
    arg_q.push_back(arg1);
  endtask

  task automatic compare_resp(input resp_t o, input string o_arg);
    resp_t e;
    string t;
    string a;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_response: got a response, expected none queued");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    a = arg_q.pop_front();
    check_int({t, ".ready_low"}, o.low, e.low);
    check_int({t, ".sel_wait"}, o.sw, e.sw);
    check_int({t, ".sel_set"}, o.ss, e.ss);
    check_int({t, ".sel_chk"}, o.sc, e.sc);
    check_int({t, ".args_valid"}, o.av, e.av);
    check_int({t, ".av_cycle"}, o.av_idx, e.av_idx);
    check_int({t, ".error"}, o.err, e.err);
    check_int({t, ".multi_sel"}, o.multi, e.multi);
    check_int({t, ".cmd_cnt"}, o.cmd_cnt, e.cmd_cnt);
    check_int({t, ".err_cnt"}, o.err_cnt, e.err_cnt);
    check_int({t, ".finished"}, o.fin, e.fin);
    if (e.av > 0) check_str({t, ".args1"}, o_arg, a);
  endtask

  // Monitor: one response per accepted command, closed when ready returns or finished rises.
  resp_t obs;
  string obs_arg;
  bit    mon_active;
  logic  mon_prev_ready;

  initial begin
    mon_active     = 1'b0;
    mon_prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && mon_prev_ready && !bus.o_cmd_ready) begin
          mon_active = 1'b1;
          obs = '{default: 0};
          obs.av_idx = -1;
          obs_arg = "";
        end
        if (mon_active) begin
          obs.sw  += int'(bus.o_sel_wait);
          obs.ss  += int'(bus.o_sel_set);
          obs.sc  += int'(bus.o_sel_chk);
          obs.err += int'(o_error);
          if ((int'(bus.o_sel_wait) + int'(bus.o_sel_set) + int'(bus.o_sel_chk)) > 1)
            obs.multi++;
          if (bus.o_args_valid) begin
            obs.av++;
            if (obs.av_idx < 0) obs.av_idx = obs.low;
            obs_arg = bus.o_args[1];
          end
          if (bus.o_cmd_ready || o_finished) begin
            obs.cmd_cnt = int'(o_cmd_cnt);
            obs.err_cnt = int'(o_err_cnt);
            obs.fin     = int'(o_finished);
            compare_resp(obs, obs_arg);
            mon_active = 1'b0;
          end else begin
            obs.low++;
          end
        end
      end
      mon_prev_ready = bus.o_cmd_ready;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic issue(input string a0, input string a1, input string a2);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_cmd_ready) begin
      checks++;
      $display("FAIL issue_timeout: ready still 0 after %0d cycles, required 1 for %s", n, a0);
    end
    bus.i_args[0] = a0;
    bus.i_args[1] = a1;
    bus.i_args[2] = a2;
    bus.i_args[3] = "";
    bus.i_args[4] = "";
    bus.i_cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag, input int n);
    rst = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_wait_done = 1'b0;
    bus.i_set_done  = 1'b0;
    bus.i_chk_done  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check_int({tag, ".ready_in_rst"}, bus.o_cmd_ready, 0);
    check_int({tag, ".sel_any"}, int'(bus.o_sel_wait) + int'(bus.o_sel_set) + int'(bus.o_sel_chk), 0);
    check_int({tag, ".args_valid"}, bus.o_args_valid, 0);
    check_int({tag, ".error"}, o_error, 0);
    check_int({tag, ".err_cnt"}, o_err_cnt, 0);
    check_int({tag, ".cmd_cnt"}, o_cmd_cnt, 0);
    check_int({tag, ".finished"}, o_finished, 0);
    check_str({tag, ".args0"}, bus.o_args[0], "");
    rst = 1'b0;
    #1;
    check_int({tag, ".ready_after"}, bus.o_cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_wait_done = 1'b0;
    bus.i_set_done  = 1'b0;
    bus.i_chk_done  = 1'b0;
    for (int i = 0; i < ARGS_NB; i++) bus.i_args[i] = "";

    do_reset("rst0", 3);

    // WTR: done driven in busy cycle 21 -> select high 21 cycles.
    expect_resp("wtr", 22, 21, 0, 0, 1, 0, 1, 0, 0, "sig0");
    issue("WTR", "sig0", "");
    wait_cycles(21);
    bus.i_wait_done = 1'b1;
    wait_cycles(1);
    bus.i_wait_done = 1'b0;

    // Delays: N cycles keep ready low for N+2 cycles from the accept cycle.
    expect_resp("wait10ns", 12, 0, 0, 0, 0, 0, 2, 0, 0, "");
    issue("WAIT", "10", "ns");
    expect_resp("wait0ps", 2, 0, 0, 0, 0, 0, 3, 0, 0, "");
    issue("WAIT", "0", "ps");
    expect_resp("wait1500ps", 3, 0, 0, 0, 0, 0, 4, 0, 0, "");
    issue("WAIT", "1500", "ps");

    // Errors.
    expect_resp("foo", 1, 0, 0, 0, 0, 1, 4, 1, 0, "");
    issue("FOO", "", "");
    expect_resp("badunit", 1, 0, 0, 0, 0, 1, 4, 2, 0, "");
    issue("WAIT", "5", "xs");

    // Watchdog abort, then done on the expiry edge.
    expect_resp("chk_wd", 51, 0, 0, 50, 1, 1, 4, 3, 0, "x");
    issue("CHK", "x", "");
    expect_resp("chk_done50", 51, 0, 0, 50, 1, 0, 5, 3, 0, "y");
    issue("CHK", "y", "");
    wait_cycles(50);
    bus.i_chk_done = 1'b1;
    wait_cycles(1);
    bus.i_chk_done = 1'b0;

    // SET with a stray wait_done in busy cycle 5, real done in cycle 10.
    expect_resp("set_stray", 11, 0, 10, 0, 1, 0, 6, 3, 0, "a");
    issue("SET", "a", "");
    wait_cycles(5);
    bus.i_wait_done = 1'b1;
    wait_cycles(1);
    bus.i_wait_done = 1'b0;
    wait_cycles(4);
    bus.i_set_done = 1'b1;
    wait_cycles(1);
    bus.i_set_done = 1'b0;

    expect_resp("wtf", 4, 3, 0, 0, 1, 0, 7, 3, 0, "z");
    issue("WTF", "z", "");
    wait_cycles(3);
    bus.i_wait_done = 1'b1;
    wait_cycles(1);
    bus.i_wait_done = 1'b0;

    // Reset in the middle of a busy SET: silent abort, no expectation queued.
    issue("SET", "b", "");
    wait_cycles(5);
    do_reset("rst_busy", 2);

    expect_resp("wait3ns", 5, 0, 0, 0, 0, 0, 1, 0, 0, "");
    issue("WAIT", "3", "ns");
    expect_resp("wait2us", 2002, 0, 0, 0, 0, 0, 2, 0, 0, "");
    issue("WAIT", "2", "us");

    expect_resp("end", 1, 0, 0, 0, 0, 0, 2, 0, 1, "");
    issue("END", "", "");

    // Commands offered after END must be ignored.
    bus.i_args[0] = "WTR";
    bus.i_args[1] = "sig1";
    bus.i_cmd_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.o_cmd_ready || bus.o_sel_wait || bus.o_sel_set || bus.o_sel_chk || bus.o_args_valid)
        bad++;
    end
    bus.i_cmd_valid = 1'b0;
    check_int("fin.ignored_cycles", bad, 0);
    check_int("fin.sticky", o_finished, 1);
    check_int("fin.cmd_cnt", o_cmd_cnt, 2);
    check_int("fin.err_cnt", o_err_cnt, 0);

    wait_cycles(3);
    check_int("sb.pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
